axi4lite_slave_regbank: RTL

- AXI4-Lite slave that terminates the transactions issued by the team's AXI4-Lite master RTL.
- Holds a bank of NUM_REGS data-width registers, addressed by word.
- Accepts the write address and write data channels independently, applies byte strobes, and returns write and read responses.
- Sits directly downstream of the master, on the same clock and reset, in the RTL-master example and the master-VIP examples.

---
 rtl/axi4lite_slave_regbank.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_slave_regbank.sv
// AXI4-Lite slave holding NUM_REGS word registers behind independent write and read FSMs.
// Every bus output is registered; dbg_data is a combinational backdoor view of one register.
module axi4lite_slave_regbank #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 16,
  localparam int STRB_W       = DATA_WIDTH / 8,
  localparam int IDX_W        = $clog2(NUM_REGS),
  localparam int LSB          = $clog2(STRB_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     awvalid,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  output logic                     awready,
  input  logic                     wvalid,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [STRB_W-1:0]        wstrb,
  output logic                     wready,
  output logic                     bvalid,
  output logic [1:0]               bresp,
  input  logic                     bready,
  input  logic                     arvalid,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  output logic                     arready,
  output logic                     rvalid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  input  logic                     rready,
  input  logic [IDX_W-1:0]         dbg_idx,
  output logic [DATA_WIDTH-1:0]    dbg_data
);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_COLLECT = 2'd1, W_RESP = 2'd2} wstate_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

  // In range exactly when every address bit above the register index is zero.
  function automatic logic addr_in_range(input logic [ADDRESS_WIDTH-1:0] a);
    return (a >> (LSB + IDX_W)) == '0;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDRESS_WIDTH-1:0] a);
    return a[LSB +: IDX_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_strobe(input logic [DATA_WIDTH-1:0] old_w,
                                                         input logic [DATA_WIDTH-1:0] new_w,
                                                         input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0]    regs_q [NUM_REGS];
  wstate_e                  wstate_q, wstate_d;
  rstate_e                  rstate_q, rstate_d;
  logic                     aw_have_q, aw_have_d, w_have_q, w_have_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic                     awready_q, awready_d, wready_q, wready_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic                     aw_hs_s, w_hs_s, ar_hs_s, commit_s;

  assign aw_hs_s  = awvalid && awready_q;
  assign w_hs_s   = wvalid && wready_q;
  assign ar_hs_s  = arvalid && arready_q;
  assign awready  = awready_q;
  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign dbg_data = regs_q[dbg_idx];

  // Write FSM: collect AW and W in any order, commit one edge after both are held, then respond.
  always_comb begin
    wstate_d  = wstate_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    commit_s  = 1'b0;
    case (wstate_q)
      W_IDLE, W_COLLECT: begin
        if (aw_have_q && w_have_q) begin
          commit_s  = 1'b1;
          bvalid_d  = 1'b1;
          bresp_d   = addr_in_range(awaddr_q) ? 2'b00 : 2'b10;
          wstate_d  = W_RESP;
        end else begin
          aw_have_d = aw_have_q | aw_hs_s;
          w_have_d  = w_have_q | w_hs_s;
          wstate_d  = (aw_have_d || w_have_d) ? W_COLLECT : W_IDLE;
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
          wstate_d  = W_IDLE;
        end else begin
          wstate_d  = W_RESP;
        end
      end
      default: begin
        wstate_d  = W_IDLE;
        aw_have_d = 1'b0;
        w_have_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
    awready_d = (wstate_d == W_IDLE) || ((wstate_d == W_COLLECT) && !aw_have_d);
    wready_d  = (wstate_d == W_IDLE) || ((wstate_d == W_COLLECT) && !w_have_d);
  end

  // Read FSM: an accepted address launches the response on the same edge, sampling pre-commit data.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = addr_in_range(araddr) ? regs_q[addr_idx(araddr)] : '0;
          rresp_d  = addr_in_range(araddr) ? 2'b00 : 2'b10;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: begin
        rstate_d = R_IDLE;
        rvalid_d = 1'b0;
      end
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  // Control and handshake state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      rstate_q  <= R_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Latched write channels and the register bank itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (aw_hs_s) awaddr_q <= awaddr;
      if (w_hs_s) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit_s && addr_in_range(awaddr_q)) begin
        regs_q[addr_idx(awaddr_q)] <= apply_strobe(regs_q[addr_idx(awaddr_q)], wdata_q, wstrb_q);
      end
    end
  end

endmodule
